// File: rtl/match_ctl.sv
// Pong match sequencer: countdown, rally gating, pause, scoring and winner.
// Every output is a flop, so the combinational block computes next-state values.
module match_ctl #(
  parameter int STEP_CYCLES = 65_000_000,
  parameter int POINT_HOLD  = 32_500_000,
  parameter int WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [1:0] countdown,
  output logic [6:0] score_l,
  output logic [6:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RALLY     = 3'd2,
    PAUSED    = 3'd3,
    POINT     = 3'd4,
    OVER      = 3'd5
  } state_t;

  localparam logic [26:0] STEP_LAST = 27'(STEP_CYCLES - 1);
  localparam logic [26:0] HOLD_LAST = 27'(POINT_HOLD - 1);
  localparam logic [6:0]  WIN       = 7'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [26:0] tick_q, tick_d;
  logic [1:0]  cd_q, cd_d;
  logic [6:0]  sl_q, sl_d, sr_q, sr_d;
  logic [1:0]  win_q, win_d;
  logic        serve_q, serve_d;
  logic        ben_q, ben_d, brst_q, brst_d;
  logic        start_q, pause_q;
  logic        start_rise, pause_rise;

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;

  always_comb begin
    state_d = state_q;
    tick_d  = '0;   // cleared on every entry and outside the timed states
    cd_d    = cd_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    win_d   = win_q;
    serve_d = serve_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d = COUNTDOWN;
          sl_d    = '0;
          sr_d    = '0;
          win_d   = 2'b00;
          cd_d    = 2'd3;
          serve_d = 1'b0;
        end
      end
      COUNTDOWN: begin
        if (tick_q == STEP_LAST) begin
          if (cd_q <= 2'd1) begin
            cd_d    = 2'd0;
            state_d = RALLY;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end else begin
          tick_d = tick_q + 27'd1;
        end
      end
      RALLY: begin
        if (goal_left) begin
          if (sr_q != WIN) sr_d = sr_q + 7'd1;
          serve_d = 1'b0;
          state_d = POINT;
        end else if (goal_right) begin
          if (sl_q != WIN) sl_d = sl_q + 7'd1;
          serve_d = 1'b1;
          state_d = POINT;
        end else if (pause_rise) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_rise) state_d = RALLY;
      end
      POINT: begin
        if (tick_q == HOLD_LAST) begin
          if (sl_q == WIN) begin
            state_d = OVER;
            win_d   = 2'b01;
          end else if (sr_q == WIN) begin
            state_d = OVER;
            win_d   = 2'b10;
          end else begin
            state_d = COUNTDOWN;
            cd_d    = 2'd3;
          end
        end else begin
          tick_d = tick_q + 27'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ben_d  = (state_d == RALLY);
    brst_d = (state_d == COUNTDOWN) && (state_q != COUNTDOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      cd_q    <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      win_q   <= '0;
      serve_q <= 1'b0;
      ben_q   <= 1'b0;
      brst_q  <= 1'b0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cd_q    <= cd_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
      serve_q <= serve_d;
      ben_q   <= ben_d;
      brst_q  <= brst_d;
      start_q <= start;
      pause_q <= pause;
    end
  end

  assign ball_en   = ben_q;
  assign ball_rst  = brst_q;
  assign serve_dir = serve_q;
  assign countdown = cd_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign winner    = win_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_match_ctl.sv
// Directed bench for match_ctl: a table of timed input phases with expected outputs,
// then hand-written sequences for reset with start held and async reset mid-countdown.
module tb_match_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
  logic       ball_en, ball_rst, serve_dir;
  logic [1:0] countdown, winner;
  logic [6:0] score_l, score_r;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  match_ctl #(.STEP_CYCLES(4), .POINT_HOLD(8), .WIN_SCORE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .goal_left(goal_left), .goal_right(goal_right),
    .ball_en(ball_en), .ball_rst(ball_rst), .serve_dir(serve_dir),
    .countdown(countdown), .score_l(score_l), .score_r(score_r),
    .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, pa, gl, gr;
    int   n;
    logic [2:0] state;
    logic ben, brst, sdir;
    logic [1:0] cd;
    logic [6:0] sl, sr;
    logic [1:0] win;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic st, pa, gl, gr, input int n,
                             input logic [2:0] s, input logic ben, brst, sdir,
                             input logic [1:0] cd, input logic [6:0] sl, sr,
                             input logic [1:0] w);
    vec_t r;
    r.st = st; r.pa = pa; r.gl = gl; r.gr = gr; r.n = n;
    r.state = s; r.ben = ben; r.brst = brst; r.sdir = sdir;
    r.cd = cd; r.sl = sl; r.sr = sr; r.win = w;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic ben, brst,
                         sdir, input logic [1:0] cd, input logic [6:0] sl, sr,
                         input logic [1:0] w);
    chk({tag, " state"}, 8'(state_o), 8'(s));
    chk({tag, " ball_en"}, 8'(ball_en), 8'(ben));
    chk({tag, " ball_rst"}, 8'(ball_rst), 8'(brst));
    chk({tag, " serve_dir"}, 8'(serve_dir), 8'(sdir));
    chk({tag, " countdown"}, 8'(countdown), 8'(cd));
    chk({tag, " score_l"}, 8'(score_l), 8'(sl));
    chk({tag, " score_r"}, 8'(score_r), 8'(sr));
    chk({tag, " winner"}, 8'(winner), 8'(w));
  endtask

  initial begin
    //           st pa gl gr  n   state ben rst dir cd sl sr win
    vt.push_back(v(1, 0, 0, 0, 1,  1, 0, 1, 0, 3, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 0, 3, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 3,  1, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 4,  1, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 1,  4, 0, 0, 1, 0, 1, 0, 0));  // goal_right
    vt.push_back(v(0, 0, 0, 0, 7,  4, 0, 0, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 1,  1, 0, 1, 1, 3, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 1, 3, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 11, 2, 1, 0, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 1, 1, 1,  4, 0, 0, 0, 0, 1, 1, 0));  // both goals
    vt.push_back(v(0, 0, 0, 0, 8,  1, 0, 1, 0, 3, 1, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 12, 2, 1, 0, 0, 0, 1, 1, 0));
    vt.push_back(v(0, 1, 0, 0, 1,  3, 0, 0, 0, 0, 1, 1, 0));  // pause
    vt.push_back(v(0, 1, 1, 0, 1,  3, 0, 0, 0, 0, 1, 1, 0));  // goal while paused
    vt.push_back(v(0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 1, 1, 0));
    vt.push_back(v(0, 1, 0, 0, 1,  2, 1, 0, 0, 0, 1, 1, 0));  // resume
    vt.push_back(v(0, 0, 0, 1, 1,  4, 0, 0, 1, 0, 2, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 8,  1, 0, 1, 1, 3, 2, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 12, 2, 1, 0, 1, 0, 2, 1, 0));
    vt.push_back(v(0, 0, 0, 1, 1,  4, 0, 0, 1, 0, 3, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 7,  4, 0, 0, 1, 0, 3, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 1,  5, 0, 0, 1, 0, 3, 1, 1));  // match over
    vt.push_back(v(0, 0, 1, 0, 1,  5, 0, 0, 1, 0, 3, 1, 1));
    vt.push_back(v(1, 0, 0, 0, 1,  1, 0, 1, 0, 3, 0, 0, 0));  // restart
    vt.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 0, 3, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 11, 2, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 1, 1, 0, 1,  4, 0, 0, 0, 0, 0, 1, 0));  // goal beats pause
    vt.push_back(v(0, 0, 0, 0, 8,  1, 0, 1, 0, 3, 0, 1, 0));
    vt.push_back(v(0, 1, 0, 0, 1,  1, 0, 0, 0, 3, 0, 1, 0));  // pause ignored
    vt.push_back(v(1, 0, 0, 0, 1,  1, 0, 0, 0, 3, 0, 1, 0));  // start ignored
    vt.push_back(v(0, 0, 0, 0, 1,  1, 0, 0, 0, 3, 0, 1, 0));

    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle state", 8'(state_o), 8'd0);

    foreach (vt[i]) begin
      start = vt[i].st; pause = vt[i].pa;
      goal_left = vt[i].gl; goal_right = vt[i].gr;
      step(vt[i].n);
      chk_all($sformatf("v%0d", i), vt[i].state, vt[i].ben, vt[i].brst, vt[i].sdir,
              vt[i].cd, vt[i].sl, vt[i].sr, vt[i].win);
    end
    start = 0; pause = 0; goal_left = 0; goal_right = 0;

    // start held high through reset release
    rst_n = 1'b0;
    start = 1'b1;
    #2;
    chk_all("held rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(3);
    chk("held no edge", 8'(state_o), 8'd0);
    start = 1'b0;
    step(1);
    chk("held released", 8'(state_o), 8'd0);
    start = 1'b1;
    step(1);
    chk("held rerise state", 8'(state_o), 8'd1);
    chk("held rerise cd", 8'(countdown), 8'd3);
    start = 1'b0;
    step(5);
    chk("mid cd", 8'(countdown), 8'd2);

    // asynchronous reset between clock edges
    rst_n = 1'b0;
    #1;
    chk_all("async rst", 0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post rst idle", 8'(state_o), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_ctl.md
Name: match_ctl

Overview:
- Match-level sequencer for the Pong game. It sits between the debounced player buttons and the ball datapath.
- It gates ball motion (ball_en), recentres the ball (ball_rst) and chooses the serve direction.
- It runs the 3-2-1 countdown, applies pause and owns both score counters.
- It declares the winner. Goal pulses come from the ball datapath; score and countdown outputs feed the display overlay.

Parameters:
STEP_CYCLES, 65_000_000, clk cycles per countdown step (1 s at 65 MHz)
POINT_HOLD, 32_500_000, clk cycles the ball stays frozen after a goal
WIN_SCORE, 10, points that end the match; legal range 1..99

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  debounced start button, level
pause  in  1  debounced pause button, level
goal_left  in  1  one-cycle pulse: ball left the left edge, so the right player scores
goal_right  in  1  one-cycle pulse: ball left the right edge, so the left player scores
ball_en  out  1  ball datapath may advance
ball_rst  out  1  one-cycle pulse: recentre ball
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
countdown  out  2  remaining countdown value 3..0
score_l  out  7  left player points
score_r  out  7  right player points
winner  out  2  00 none, 01 left, 10 right
state_o  out  3  current state encoding, for the overlay

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state = IDLE
  - ball_en = 0, ball_rst = 0, serve_dir = 0, countdown = 0
  - score_l = 0, score_r = 0, winner = 00
  - tick counter = 0
  - button history registers = 1, so a button held through reset produces no edge.
- Edge detection: start_rise = start & ~start_q, and likewise pause_rise. Only rises act; holding a button does nothing further.
- State encodings: IDLE = 0, COUNTDOWN = 1, RALLY = 2, PAUSED = 3, POINT = 4, OVER = 5. Undefined encodings go to IDLE.
- IDLE:
  - ball_en = 0.
  - On start_rise: go to COUNTDOWN. Clear scores and winner, set countdown = 3, clear tick, serve_dir = 0.
- COUNTDOWN:
  - ball_en = 0. ball_rst is high exactly in the first cycle of COUNTDOWN, on every entry.
  - tick counts 0..STEP_CYCLES-1. On wrap, countdown decrements.
  - On the wrap while countdown = 1: countdown becomes 0 and the next state is RALLY.
  - Duration is exactly 3*STEP_CYCLES cycles.
  - start and pause are ignored.
- RALLY:
  - ball_en = 1 in every RALLY cycle.
  - goal_left at cycle N: at N+1, score_r increments, serve_dir = 0, state = POINT, ball_en = 0, tick = 0.
  - goal_right at cycle N: same, but score_l increments and serve_dir = 1.
  - Both goals in the same cycle: goal_left has priority; goal_right is dropped.
  - Goal and pause_rise in the same cycle: the goal wins and the pause is dropped.
  - pause_rise alone: go to PAUSED at N+1 with ball_en = 0.
- PAUSED:
  - ball_en = 0. Scores and serve_dir are held; goals are ignored.
  - pause_rise returns to RALLY. start_rise is ignored.
- POINT:
  - ball_en = 0. tick counts to POINT_HOLD-1, then:
    - If score_l == WIN_SCORE, go to OVER with winner = 01.
    - If score_r == WIN_SCORE, go to OVER with winner = 10.
    - Otherwise go to COUNTDOWN with countdown = 3 (ball_rst pulses there).
  - Goals received while in POINT are ignored.
- OVER:
  - ball_en = 0. Scores and winner are held.
  - On start_rise: go to COUNTDOWN with scores cleared, winner = 00, serve_dir = 0.
- Scores:
  - 7-bit unsigned. An increment never exceeds WIN_SCORE, because OVER is entered first.
  - A score that is already equal to WIN_SCORE is not incremented.
- Tick counter: 27 bits. It is cleared on every state entry and never free-runs outside COUNTDOWN or POINT.
- Reset mid-operation: rst_n low in any state returns to the reset values immediately, without waiting for a clock edge.

Test Plan:
(Simulation parameters: STEP_CYCLES = 4, POINT_HOLD = 8, WIN_SCORE = 3.)
- Reset, then start_rise:
  - Next cycle: state 1, countdown 3, ball_rst = 1 for one cycle.
  - countdown reads 2 after 4 cycles and 1 after 8.
  - At 12 cycles: state 2 and ball_en = 1.
- In RALLY, goal_right pulse:
  - Next cycle: score_l = 1, serve_dir = 1, state 4, ball_en = 0.
  - 8 cycles later: state 1 with a ball_rst pulse.
- In RALLY, goal_left and goal_right together:
  - Only score_r increments (0 -> 1); score_l is unchanged; serve_dir = 0.
- In RALLY, pause_rise:
  - State 3, ball_en = 0; goal_left injected here leaves score_r unchanged.
  - A second pause_rise returns to state 2 with ball_en = 1.
- Three goal_right pulses, each sent after RALLY resumes:
  - score_l = 3; after POINT_HOLD: state 5, winner = 01.
  - A further goal is ignored.
  - start_rise gives state 1 with scores 0/0 and winner = 00.
- start held high through reset release:
  - No transition occurs; state stays 0 until start falls and rises again.
- rst_n asserted mid-COUNTDOWN:
  - Outputs go to their reset values asynchronously; state 0.
